control_unit: RTL and testbench

Multi-cycle fetch/decode/execute sequencer for the tiny16 core. It owns the instruction register and the Z/C flags, and drives the register-file selects and enables, including the PC (r0) increment, the memory request handshake, and the ALU opcode. It sits between the 16-bit register file, the ALU and the single-ported memory bus, and guarantees that the register-file write and the PC increment are never asserted in the same cycle.

---
 rtl/tiny16_pkg.sv | 35 +++
 rtl/instr_decode.sv | 44 ++++
 rtl/control_unit.sv | 158 +++++++++++++++
 tb/tb_control_unit.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/tiny16_pkg.sv
// Shared types and encodings for the tiny16 core control path.
package tiny16_pkg;

    typedef enum logic [3:0] {
        OpNop = 4'd0,  OpMov = 4'd1,  OpLdi = 4'd2,  OpAdd = 4'd3,
        OpSub = 4'd4,  OpAnd = 4'd5,  OpOr  = 4'd6,  OpXor = 4'd7,
        OpLd  = 4'd8,  OpSt  = 4'd9,  OpJmp = 4'd10, OpJz  = 4'd11,
        OpR12 = 4'd12, OpR13 = 4'd13, OpR14 = 4'd14, OpHlt = 4'd15
    } opcode_e;

    typedef enum logic [2:0] {
        StIdle, StFetch, StDecode, StExec, StMemRd, StMemWr, StHalt
    } state_e;

    typedef enum logic [2:0] {
        ClsNop, ClsExec, ClsJz, ClsLoad, ClsStore, ClsHalt
    } op_class_e;

    localparam logic [1:0] InSelAlu = 2'd0;
    localparam logic [1:0] InSelMem = 2'd1;
    localparam logic [1:0] InSelImm = 2'd2;
    localparam logic [1:0] InSelSrc = 2'd3;

    localparam logic [1:0] AddrSelPc  = 2'd0;
    localparam logic [1:0] AddrSelSrc = 2'd1;
    localparam logic [1:0] AddrSelDst = 2'd2;

    localparam logic [2:0] AluAdd  = 3'd0;
    localparam logic [2:0] AluSub  = 3'd1;
    localparam logic [2:0] AluAnd  = 3'd2;
    localparam logic [2:0] AluOr   = 3'd3;
    localparam logic [2:0] AluXor  = 3'd4;
    localparam logic [2:0] AluPass = 3'd5;

endpackage

// File: rtl/instr_decode.sv
// Combinational opcode decoder: classifies the instruction and picks the
// write-back source, ALU function and flag behaviour.
module instr_decode
    import tiny16_pkg::*;
(
    input  opcode_e    opcode,
    output op_class_e  op_class,
    output logic [2:0] alu_op,
    output logic [1:0] in_sel,
    output logic       wr_en,
    output logic       jump,
    output logic       sets_flags,
    output logic       clear_c,
    output logic       illegal
);

    always_comb begin
        op_class   = ClsExec;
        alu_op     = AluPass;
        in_sel     = InSelAlu;
        wr_en      = 1'b0;
        jump       = 1'b0;
        sets_flags = 1'b0;
        clear_c    = 1'b0;
        illegal    = 1'b0;
        case (opcode)
            OpNop: op_class = ClsNop;
            OpMov: begin wr_en = 1'b1; in_sel = InSelSrc; end
            OpLdi: begin wr_en = 1'b1; in_sel = InSelImm; end
            OpAdd: begin wr_en = 1'b1; alu_op = AluAdd; sets_flags = 1'b1; end
            OpSub: begin wr_en = 1'b1; alu_op = AluSub; sets_flags = 1'b1; end
            OpAnd: begin wr_en = 1'b1; alu_op = AluAnd; sets_flags = 1'b1; clear_c = 1'b1; end
            OpOr:  begin wr_en = 1'b1; alu_op = AluOr;  sets_flags = 1'b1; clear_c = 1'b1; end
            OpXor: begin wr_en = 1'b1; alu_op = AluXor; sets_flags = 1'b1; clear_c = 1'b1; end
            OpLd:  begin op_class = ClsLoad; wr_en = 1'b1; in_sel = InSelMem; end
            OpSt:  op_class = ClsStore;
            OpJmp: begin wr_en = 1'b1; jump = 1'b1; in_sel = InSelSrc; end
            OpJz:  begin op_class = ClsJz; wr_en = 1'b1; jump = 1'b1; in_sel = InSelSrc; end
            OpHlt: op_class = ClsHalt;
            default: begin op_class = ClsHalt; illegal = 1'b1; end
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle fetch/decode/execute sequencer for tiny16; owns IR and Z/C flags
// and drives register-file, memory and ALU controls.
module control_unit
    import tiny16_pkg::*;
#(
    parameter int unsigned RESET_PC_HOLD = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ready,
    input  logic        alu_z,
    input  logic        alu_c,
    output logic        mem_req,
    output logic        mem_we,
    output logic [1:0]  addr_sel,
    output logic [2:0]  src_sel,
    output logic [2:0]  dst_sel,
    output logic        in_en,
    output logic [1:0]  in_sel,
    output logic        pc_inc,
    output logic [2:0]  alu_op,
    output logic [15:0] ir,
    output logic [1:0]  flags,
    output logic        halted,
    output logic        illegal
);

    state_e      state_q, state_d;
    logic [3:0]  hold_q, hold_d;
    logic [15:0] ir_q, ir_d;
    logic [1:0]  flags_q, flags_d;

    op_class_e  dec_class;
    logic [2:0] dec_alu_op;
    logic [1:0] dec_in_sel;
    logic       dec_wr_en, dec_jump, dec_sets_flags, dec_clear_c, dec_illegal;

    instr_decode u_decode (
        .opcode     (opcode_e'(ir_q[15:12])),
        .op_class   (dec_class),
        .alu_op     (dec_alu_op),
        .in_sel     (dec_in_sel),
        .wr_en      (dec_wr_en),
        .jump       (dec_jump),
        .sets_flags (dec_sets_flags),
        .clear_c    (dec_clear_c),
        .illegal    (dec_illegal)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            hold_q  <= 4'd0;
            ir_q    <= 16'h0000;
            flags_q <= 2'b00;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            ir_q    <= ir_d;
            flags_q <= flags_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        hold_d   = hold_q;
        ir_d     = ir_q;
        flags_d  = flags_q;
        mem_req  = 1'b0;
        mem_we   = 1'b0;
        addr_sel = AddrSelPc;
        src_sel  = 3'd0;
        dst_sel  = 3'd0;
        in_en    = 1'b0;
        in_sel   = InSelAlu;
        pc_inc   = 1'b0;
        alu_op   = 3'd0;
        halted   = 1'b0;
        illegal  = 1'b0;
        case (state_q)
            StIdle: begin
                if (hold_q == 4'(RESET_PC_HOLD - 1)) begin
                    hold_d  = 4'd0;
                    state_d = StFetch;
                end else begin
                    hold_d = hold_q + 4'd1;
                end
            end
            StFetch: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_d    = mem_rdata;
                    pc_inc  = 1'b1;
                    state_d = StDecode;
                end
            end
            StDecode: begin
                src_sel = ir_q[8:6];
                dst_sel = ir_q[11:9];
                case (dec_class)
                    ClsHalt:  state_d = StHalt;
                    ClsLoad:  state_d = StMemRd;
                    ClsStore: state_d = StMemWr;
                    ClsNop:   state_d = StFetch;
                    ClsJz:    state_d = flags_q[0] ? StExec : StFetch;
                    default:  state_d = StExec;
                endcase
            end
            StExec: begin
                src_sel = ir_q[8:6];
                dst_sel = dec_jump ? 3'd0 : ir_q[11:9];
                in_en   = dec_wr_en;
                in_sel  = dec_in_sel;
                alu_op  = dec_alu_op;
                if (dec_sets_flags) begin
                    flags_d = {alu_c & ~dec_clear_c, alu_z};
                end
                state_d = StFetch;
            end
            StMemRd: begin
                mem_req  = 1'b1;
                addr_sel = AddrSelSrc;
                src_sel  = ir_q[8:6];
                dst_sel  = ir_q[11:9];
                if (mem_ready) begin
                    in_en   = 1'b1;
                    in_sel  = InSelMem;
                    state_d = StFetch;
                end
            end
            StMemWr: begin
                mem_req  = 1'b1;
                mem_we   = 1'b1;
                addr_sel = AddrSelDst;
                src_sel  = ir_q[8:6];
                dst_sel  = ir_q[11:9];
                if (mem_ready) begin
                    state_d = StFetch;
                end
            end
            StHalt: begin
                // IR is frozen here, so the decoder's illegal flag records the cause.
                halted  = 1'b1;
                illegal = dec_illegal;
            end
            default: state_d = StIdle;
        endcase
    end

    assign ir    = ir_q;
    assign flags = flags_q;

    a_in_pc_excl: assert property (@(posedge clk) disable iff (rst) !(in_en && pc_inc));
    a_pc_fetch:   assert property (@(posedge clk) disable iff (rst) pc_inc |-> state_q == StFetch);
    a_we_memwr:   assert property (@(posedge clk) disable iff (rst) mem_we |-> state_q == StMemWr);

endmodule

// File: tb/tb_control_unit.sv
// Directed and random-sweep bench for control_unit.
module tb_control_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] mem_rdata;
    logic        mem_ready;
    logic        alu_z;
    logic        alu_c;
    logic        mem_req;
    logic        mem_we;
    logic [1:0]  addr_sel;
    logic [2:0]  src_sel;
    logic [2:0]  dst_sel;
    logic        in_en;
    logic [1:0]  in_sel;
    logic        pc_inc;
    logic [2:0]  alu_op;
    logic [15:0] ir;
    logic [1:0]  flags;
    logic        halted;
    logic        illegal;

    int n_run  = 0;
    int n_fail = 0;

    control_unit #(.RESET_PC_HOLD(1)) dut (
        .clk       (clk),
        .rst       (rst),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .alu_z     (alu_z),
        .alu_c     (alu_c),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .addr_sel  (addr_sel),
        .src_sel   (src_sel),
        .dst_sel   (dst_sel),
        .in_en     (in_en),
        .in_sel    (in_sel),
        .pc_inc    (pc_inc),
        .alu_op    (alu_op),
        .ir        (ir),
        .flags     (flags),
        .halted    (halted),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    function automatic logic [36:0] all_outs();
        return {mem_req, mem_we, addr_sel, src_sel, dst_sel, in_en, in_sel, pc_inc,
                alu_op, ir, flags, halted, illegal};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Completes a zero-wait fetch; leaves the DUT in DECODE.
    task automatic fetch(input logic [15:0] instr);
        mem_rdata = instr;
        mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;
        mem_rdata = 16'h0000;
    endtask

    task automatic test_reset();
        rst = 1'b1; mem_ready = 1'b0; mem_rdata = 16'h0000; alu_z = 1'b0; alu_c = 1'b0;
        step(); step(); #1;
        n_run++; if (all_outs() !== 37'd0) begin n_fail++; $display("FAIL reset_outs: got %h want 0", all_outs()); end
        rst = 1'b0; #1;
        n_run++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL idle_req: got %b want 0", mem_req); end
        step(); #1;
        n_run++; if ({mem_req, mem_we, addr_sel} !== 4'b1000) begin n_fail++; $display("FAIL first_fetch: got %b want 1000", {mem_req, mem_we, addr_sel}); end
        n_run++; if (pc_inc !== 1'b0) begin n_fail++; $display("FAIL fetch_wait_pcinc: got %b want 0", pc_inc); end
    endtask

    task automatic test_ldi_alu_jz();
        // LDI r2,5 with explicit strobe checks
        mem_rdata = 16'h2405; mem_ready = 1'b1; #1;
        n_run++; if ({pc_inc, in_en} !== 2'b10) begin n_fail++; $display("FAIL fetch_strobe: got %b want 10", {pc_inc, in_en}); end
        step(); mem_ready = 1'b0; #1;
        n_run++; if ({ir, mem_req, in_en, pc_inc, dst_sel} !== {16'h2405, 3'b000, 3'd2}) begin n_fail++; $display("FAIL ldi_decode: got %h want %h", {ir, mem_req, in_en, pc_inc, dst_sel}, {16'h2405, 3'b000, 3'd2}); end
        step(); #1;
        n_run++; if ({in_en, in_sel, dst_sel} !== {1'b1, 2'd2, 3'd2}) begin n_fail++; $display("FAIL ldi_exec: got %b want 110010", {in_en, in_sel, dst_sel}); end
        step(); #1;
        n_run++; if ({mem_req, addr_sel} !== 3'b100) begin n_fail++; $display("FAIL ldi_latency: got %b want 100", {mem_req, addr_sel}); end
        // LDI r3,5
        fetch(16'h2605); step(); step();
        // SUB r2,r3 -> Z
        fetch(16'h44C0); step(); alu_z = 1'b1; alu_c = 1'b0; #1;
        n_run++; if ({in_en, alu_op, in_sel, dst_sel, src_sel} !== {1'b1, 3'd1, 2'd0, 3'd2, 3'd3}) begin n_fail++; $display("FAIL sub_exec: got %b want 10010001011", {in_en, alu_op, in_sel, dst_sel, src_sel}); end
        step(); alu_z = 1'b0; #1;
        n_run++; if (flags !== 2'b01) begin n_fail++; $display("FAIL sub_flags: got %b want 01", flags); end
        // JZ r4 taken
        fetch(16'hB100); step(); #1;
        n_run++; if ({in_en, dst_sel, in_sel, src_sel} !== {1'b1, 3'd0, 2'd3, 3'd4}) begin n_fail++; $display("FAIL jz_taken: got %b want 100011100", {in_en, dst_sel, in_sel, src_sel}); end
        step(); #1;
        n_run++; if ({mem_req, addr_sel} !== 3'b100) begin n_fail++; $display("FAIL jz_taken_latency: got %b want 100", {mem_req, addr_sel}); end
        // AND r1,r1 clears C even when the ALU reports carry
        fetch(16'h5240); step(); alu_c = 1'b1; alu_z = 1'b0; step(); alu_c = 1'b0; #1;
        n_run++; if (flags !== 2'b00) begin n_fail++; $display("FAIL and_flags: got %b want 00", flags); end
        // ADD r1,r1 with carry
        fetch(16'h3240); step(); alu_c = 1'b1; step(); alu_c = 1'b0; #1;
        n_run++; if (flags !== 2'b10) begin n_fail++; $display("FAIL add_flags: got %b want 10", flags); end
        // JZ r4 not taken
        fetch(16'hB100); #1;
        n_run++; if (in_en !== 1'b0) begin n_fail++; $display("FAIL jz_nt_decode: got %b want 0", in_en); end
        step(); #1;
        n_run++; if ({mem_req, addr_sel, in_en, flags} !== 6'b100010) begin n_fail++; $display("FAIL jz_not_taken: got %b want 100010", {mem_req, addr_sel, in_en, flags}); end
    endtask

    task automatic test_ld_wait();
        int reqs = 0;
        int pulses = 0;
        int unstable = 0;
        fetch(16'h83C0); step();
        for (int i = 0; i < 3; i++) begin
            #1;
            if (mem_req) reqs++;
            if (in_en) pulses++;
            if (addr_sel !== 2'd1 || mem_we !== 1'b0) unstable++;
            step();
        end
        mem_ready = 1'b1; mem_rdata = 16'h1234; #1;
        if (mem_req) reqs++;
        if (in_en) pulses++;
        n_run++; if ({in_en, in_sel, dst_sel, addr_sel} !== {1'b1, 2'd1, 3'd1, 2'd1}) begin n_fail++; $display("FAIL ld_ready: got %b want 10100101", {in_en, in_sel, dst_sel, addr_sel}); end
        step(); mem_ready = 1'b0; #1;
        if (in_en) pulses++;
        n_run++; if (reqs !== 4) begin n_fail++; $display("FAIL ld_req_cycles: got %0d want 4", reqs); end
        n_run++; if (pulses !== 1) begin n_fail++; $display("FAIL ld_in_en_pulses: got %0d want 1", pulses); end
        n_run++; if (unstable !== 0) begin n_fail++; $display("FAIL ld_addr_stable: got %0d want 0", unstable); end
        n_run++; if ({mem_req, addr_sel} !== 3'b100) begin n_fail++; $display("FAIL ld_back_to_fetch: got %b want 100", {mem_req, addr_sel}); end
    endtask

    task automatic test_st();
        fetch(16'h9D40); step(); #1;
        n_run++; if ({mem_req, mem_we, addr_sel, src_sel, dst_sel, in_en} !== {2'b11, 2'd2, 3'd5, 3'd6, 1'b0}) begin n_fail++; $display("FAIL st_wait: got %b want 11101011100", {mem_req, mem_we, addr_sel, src_sel, dst_sel, in_en}); end
        step(); mem_ready = 1'b1; #1;
        n_run++; if ({mem_we, addr_sel, src_sel} !== {1'b1, 2'd2, 3'd5}) begin n_fail++; $display("FAIL st_ready: got %b want 110101", {mem_we, addr_sel, src_sel}); end
        step(); mem_ready = 1'b0; #1;
        n_run++; if ({mem_req, mem_we, addr_sel, flags} !== 6'b100010) begin n_fail++; $display("FAIL st_done: got %b want 100010", {mem_req, mem_we, addr_sel, flags}); end
    endtask

    task automatic test_reset_mid_exec();
        fetch(16'h2405); step(); #1;
        n_run++; if (in_en !== 1'b1) begin n_fail++; $display("FAIL pre_reset_exec: got %b want 1", in_en); end
        rst = 1'b1; #1;
        n_run++; if (all_outs() !== 37'd0) begin n_fail++; $display("FAIL async_reset: got %h want 0", all_outs()); end
        step(); rst = 1'b0; #1;
        n_run++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL restart_idle: got %b want 0", mem_req); end
        step(); #1;
        n_run++; if ({mem_req, addr_sel} !== 3'b100) begin n_fail++; $display("FAIL restart_fetch: got %b want 100", {mem_req, addr_sel}); end
    endtask

    task automatic test_halt();
        int busy = 0;
        fetch(16'hF000); step(); mem_ready = 1'b1; #1;
        n_run++; if ({halted, illegal} !== 2'b10) begin n_fail++; $display("FAIL hlt: got %b want 10", {halted, illegal}); end
        for (int i = 0; i < 5; i++) begin
            step(); #1;
            if (mem_req || in_en || pc_inc || !halted) busy++;
        end
        n_run++; if (busy !== 0) begin n_fail++; $display("FAIL hlt_stays: got %0d want 0", busy); end
        mem_ready = 1'b0;
        rst = 1'b1; #1;
        n_run++; if (halted !== 1'b0) begin n_fail++; $display("FAIL hlt_reset: got %b want 0", halted); end
        step(); rst = 1'b0; step();
        fetch(16'hD000); step(); #1;
        n_run++; if ({halted, illegal} !== 2'b11) begin n_fail++; $display("FAIL illegal_op: got %b want 11", {halted, illegal}); end
        rst = 1'b1; #1;
        n_run++; if ({halted, illegal} !== 2'b00) begin n_fail++; $display("FAIL illegal_reset: got %b want 00", {halted, illegal}); end
        step(); rst = 1'b0; step(); #1;
        n_run++; if ({mem_req, addr_sel} !== 3'b100) begin n_fail++; $display("FAIL illegal_recover: got %b want 100", {mem_req, addr_sel}); end
    endtask

    task automatic test_sweep();
        int bad = 0;
        for (int i = 0; i < 20000; i++) begin
            step();
            if (halted) begin
                rst = 1'b1; #1; rst = 1'b0;
            end
            mem_ready = 1'($urandom_range(0, 1));
            mem_rdata = 16'($urandom);
            alu_z     = 1'($urandom_range(0, 1));
            alu_c     = 1'($urandom_range(0, 1));
            #1;
            if (in_en && pc_inc) bad++;
            if (mem_we && !(mem_req && addr_sel == 2'd2 && !in_en)) bad++;
            if (pc_inc && !(mem_req && addr_sel == 2'd0 && !mem_we)) bad++;
        end
        n_run++; if (bad !== 0) begin n_fail++; $display("FAIL invariant_sweep: got %0d violations want 0", bad); end
    endtask

    initial begin
        test_reset();
        test_ldi_alu_jz();
        test_ld_wait();
        test_st();
        test_reset_mid_exec();
        test_halt();
        test_sweep();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
